// File: rtl/qspi_psram_pkg.sv
// Shared definitions for the QPI PSRAM responder model.
//   OP_QREAD / OP_QWRITE : the two opcodes the responder accepts
//   state_t              : bus engine states
//   ADDR_NIBBLES         : nibbles in the 24-bit bus address
package qspi_psram_pkg;

    localparam logic [7:0] OP_QREAD  = 8'hEB;
    localparam logic [7:0] OP_QWRITE = 8'h38;
    localparam int         ADDR_NIBBLES = 6;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WAIT,
        RDATA,
        WDATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/psram_mem_array.sv
// Byte memory behind the responder.
//   clk                         : write clock
//   q_we/q_waddr/q_wdata        : write port from the bus engine
//   bd_we/bd_addr/bd_wdata      : backdoor write port
//   eng_raddr -> eng_rdata      : asynchronous read for the bus engine
//   bd_addr   -> bd_rdata       : asynchronous read for the backdoor
// Both write sources share one synchronous write port; when they target
// the same byte on the same edge the bus engine write lands last and wins.
module psram_mem_array #(
    parameter int          ADDR_BITS = 16,
    parameter logic [7:0]  INIT_VAL  = 8'h00
) (
    input  logic                 clk,
    input  logic                 q_we,
    input  logic [ADDR_BITS-1:0] q_waddr,
    input  logic [7:0]           q_wdata,
    input  logic                 bd_we,
    input  logic [ADDR_BITS-1:0] bd_addr,
    input  logic [7:0]           bd_wdata,
    input  logic [ADDR_BITS-1:0] eng_raddr,
    output logic [7:0]           eng_rdata,
    output logic [7:0]           bd_rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // Contents start at INIT_VAL; reset never touches the array.
    logic [7:0] mem [0:DEPTH-1] = '{default: INIT_VAL};

    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_wdata;
        end
        if (q_we) begin
            mem[q_waddr] <= q_wdata;
        end
    end

    assign eng_rdata = mem[eng_raddr];
    assign bd_rdata  = mem[bd_addr];

endmodule

// File: rtl/qspi_psram_responder.sv
// QPI PSRAM responder: decodes quad read (0xEB) and quad write (0x38)
// transactions on a 4-bit bus and serves them from an internal byte memory.
//   clk, rst          : bus clock, asynchronous active-high reset
//   cs_n, io_i        : chip select and nibble from the controller
//   io_o, io_oe       : read-data nibble and its output enable
//   cmd_err           : one-cycle pulse on an unsupported opcode
//   bd_we/bd_addr/bd_wdata/bd_rdata : backdoor access to the memory
module qspi_psram_responder
    import qspi_psram_pkg::*;
#(
    parameter int          ADDR_BITS   = 16,
    parameter int          WAIT_CYCLES = 6,
    parameter logic [7:0]  INIT_VAL    = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs_n,
    input  logic [3:0]           io_i,
    output logic [3:0]           io_o,
    output logic                 io_oe,
    output logic                 cmd_err,
    input  logic                 bd_we,
    input  logic [ADDR_BITS-1:0] bd_addr,
    input  logic [7:0]           bd_wdata,
    output logic [7:0]           bd_rdata
);

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    state_t                 state_reg,   state_next;
    logic [3:0]             cmd_hi_reg,  cmd_hi_next;
    logic [3:0]             cnt_reg,     cnt_next;
    logic                   is_read_reg, is_read_next;
    logic [ADDR_BITS-1:0]   addr_reg,    addr_next;
    logic                   half_reg,    half_next;   // 1: next nibble is a low half
    logic [3:0]             wr_hi_reg,   wr_hi_next;
    logic [3:0]             io_o_reg,    io_o_next;
    logic                   io_oe_reg,   io_oe_next;
    logic                   cmd_err_reg, cmd_err_next;

    logic                   q_we;
    logic [7:0]             q_wdata;
    logic [7:0]             eng_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cmd_hi_reg  <= '0;
            cnt_reg     <= '0;
            is_read_reg <= 1'b0;
            addr_reg    <= '0;
            half_reg    <= 1'b0;
            wr_hi_reg   <= '0;
            io_o_reg    <= '0;
            io_oe_reg   <= 1'b0;
            cmd_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cmd_hi_reg  <= cmd_hi_next;
            cnt_reg     <= cnt_next;
            is_read_reg <= is_read_next;
            addr_reg    <= addr_next;
            half_reg    <= half_next;
            wr_hi_reg   <= wr_hi_next;
            io_o_reg    <= io_o_next;
            io_oe_reg   <= io_oe_next;
            cmd_err_reg <= cmd_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cmd_hi_next  = cmd_hi_reg;
        cnt_next     = cnt_reg;
        is_read_next = is_read_reg;
        addr_next    = addr_reg;
        half_next    = half_reg;
        wr_hi_next   = wr_hi_reg;
        io_o_next    = io_o_reg;
        io_oe_next   = io_oe_reg;
        cmd_err_next = 1'b0;
        q_we         = 1'b0;
        q_wdata      = {wr_hi_reg, io_i};

        if (cs_n) begin
            // Deselect aborts everything; a pending high write nibble is dropped.
            state_next = IDLE;
            cnt_next   = '0;
            half_next  = 1'b0;
            io_o_next  = '0;
            io_oe_next = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    cmd_hi_next = io_i;
                    addr_next   = '0;
                    cnt_next    = '0;
                    state_next  = CMD;
                end
                CMD: begin
                    if ({cmd_hi_reg, io_i} == OP_QREAD) begin
                        is_read_next = 1'b1;
                        state_next   = ADDR;
                    end else if ({cmd_hi_reg, io_i} == OP_QWRITE) begin
                        is_read_next = 1'b0;
                        state_next   = ADDR;
                    end else begin
                        cmd_err_next = 1'b1;
                        state_next   = IGNORE;
                    end
                end
                ADDR: begin
                    // Shifting left keeps only the low ADDR_BITS of the 24-bit address.
                    addr_next = {addr_reg[ADDR_BITS-5:0], io_i};
                    if (cnt_reg == 4'(ADDR_NIBBLES - 1)) begin
                        cnt_next   = '0;
                        half_next  = 1'b0;
                        state_next = is_read_reg ? WAIT : WDATA;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'(WAIT_CYCLES - 1)) begin
                        // Launch the first high nibble so it is valid at the next edge.
                        io_oe_next = 1'b1;
                        io_o_next  = eng_rdata[7:4];
                        half_next  = 1'b1;
                        state_next = RDATA;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
                RDATA: begin
                    if (half_reg) begin
                        io_o_next = eng_rdata[3:0];
                        addr_next = addr_reg + ADDR_ONE;
                        half_next = 1'b0;
                    end else begin
                        io_o_next = eng_rdata[7:4];
                        half_next = 1'b1;
                    end
                end
                WDATA: begin
                    if (half_reg) begin
                        q_we      = 1'b1;
                        addr_next = addr_reg + ADDR_ONE;
                        half_next = 1'b0;
                    end else begin
                        wr_hi_next = io_i;
                        half_next  = 1'b1;
                    end
                end
                IGNORE: begin
                    state_next = IGNORE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    psram_mem_array #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_VAL  (INIT_VAL)
    ) u_mem (
        .clk       (clk),
        .q_we      (q_we),
        .q_waddr   (addr_reg),
        .q_wdata   (q_wdata),
        .bd_we     (bd_we),
        .bd_addr   (bd_addr),
        .bd_wdata  (bd_wdata),
        .eng_raddr (addr_reg),
        .eng_rdata (eng_rdata),
        .bd_rdata  (bd_rdata)
    );

    assign io_o    = io_o_reg;
    assign io_oe   = io_oe_reg;
    assign cmd_err = cmd_err_reg;

endmodule

// File: tb/tb_qspi_psram_responder.sv
module tb_qspi_psram_responder;

    localparam int AW = 16;
    localparam int WC = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs_n;
    logic [3:0]    io_i;
    logic [3:0]    io_o;
    logic          io_oe;
    logic          cmd_err;
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [7:0]    bd_wdata;
    logic [7:0]    bd_rdata;

    int total = 0;
    int bad   = 0;
    int nib_idx = 0;
    int oe_seen = 0;
    logic wr_active = 1'b0;
    logic [3:0] exp_q[$];

    qspi_psram_responder #(
        .ADDR_BITS   (AW),
        .WAIT_CYCLES (WC),
        .INIT_VAL    (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cs_n     (cs_n),
        .io_i     (io_i),
        .io_o     (io_o),
        .io_oe    (io_oe),
        .cmd_err  (cmd_err),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .bd_rdata (bd_rdata)
    );

    always #5 clk = ~clk;

    // Monitor: the controller samples io_o at every edge where cs_n is low
    // and io_oe is high; the value is checked half a cycle earlier.
    always @(negedge clk) begin
        if (!rst && wr_active && io_oe) begin
            oe_seen++;
        end
        if (!rst && !cs_n && io_oe) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_nib[%0d] unexpected: got %h, none required", nib_idx, io_o);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (io_o !== e) begin
                    bad++;
                    $display("FAIL rd_nib[%0d]: got %h, required %h", nib_idx, io_o, e);
                end else begin
                    $display("rd_nib[%0d] ok: %h", nib_idx, io_o);
                end
            end
            nib_idx++;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end else begin
            $display("%s ok: %0h", nm, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] n);
        cs_n = 1'b0;
        io_i = n;
        tick();
    endtask

    task automatic end_txn();
        cs_n = 1'b1;
        io_i = 4'h0;
        tick();
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
        send_nib(op[7:4]);
        send_nib(op[3:0]);
        for (int i = 5; i >= 0; i--) begin
            send_nib(a[i*4 +: 4]);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b[7:4]);
        exp_q.push_back(b[3:0]);
    endtask

    // Header plus dummy cycles; io_oe must rise exactly on the last dummy edge.
    task automatic rd_start(input logic [23:0] a);
        send_hdr(8'hEB, a);
        for (int d = 0; d < WC; d++) begin
            send_nib(4'h0);
            if (d == WC - 2) check("oe_before_rise", {31'd0, io_oe}, 32'd0);
        end
        check("oe_rise", {31'd0, io_oe}, 32'd1);
    endtask

    task automatic rd_data(input int n);
        for (int i = 0; i < n; i++) begin
            send_nib(4'h0);
        end
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
        bd_we    = 1'b1;
        bd_addr  = a;
        bd_wdata = d;
        tick();
        bd_we    = 1'b0;
    endtask

    task automatic peek(input string nm, input logic [AW-1:0] a, input logic [7:0] e);
        bd_addr = a;
        #1;
        check(nm, {24'd0, bd_rdata}, {24'd0, e});
    endtask

    initial begin
        rst = 1'b1; cs_n = 1'b1; io_i = 4'h0;
        bd_we = 1'b0; bd_addr = '0; bd_wdata = 8'h00;
        tick(); tick();
        check("rst_io_oe",   {31'd0, io_oe},   32'd0);
        check("rst_io_o",    {28'd0, io_o},    32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        peek("init_val", 16'h1234, 8'h00);
        rst = 1'b0;
        tick();

        // Preload and quad read of 8 nibbles
        bd_write(16'h0010, 8'hA5);
        bd_write(16'h0011, 8'h3C);
        bd_write(16'h0012, 8'h7E);
        bd_write(16'h0013, 8'h01);
        push_byte(8'hA5); push_byte(8'h3C); push_byte(8'h7E); push_byte(8'h01);
        rd_start(24'h000010);
        rd_data(8);
        end_txn();
        check("rd1_drain", exp_q.size(), 0);

        // Quad write 1,2,3,4 at 0x200
        wr_active = 1'b1; oe_seen = 0;
        send_hdr(8'h38, 24'h000200);
        send_nib(4'h1); send_nib(4'h2); send_nib(4'h3); send_nib(4'h4);
        end_txn();
        wr_active = 1'b0;
        check("wr_oe", oe_seen, 0);
        peek("wr_0200", 16'h0200, 8'h12);
        peek("wr_0201", 16'h0201, 8'h34);

        // Write across the top of memory, then read it back
        send_hdr(8'h38, 24'h00FFFF);
        send_nib(4'hD); send_nib(4'hE); send_nib(4'hA); send_nib(4'hD);
        end_txn();
        peek("wrap_ffff", 16'hFFFF, 8'hDE);
        peek("wrap_0000", 16'h0000, 8'hAD);
        push_byte(8'hDE); push_byte(8'hAD);
        rd_start(24'h00FFFF);
        rd_data(4);
        end_txn();
        check("rd_wrap_drain", exp_q.size(), 0);

        // Unsupported opcode: pulse at k=1 only, rest of the transaction inert
        wr_active = 1'b1; oe_seen = 0;
        send_nib(4'h9);
        check("err_k0", {31'd0, cmd_err}, 32'd0);
        send_nib(4'hF);
        check("err_k1", {31'd0, cmd_err}, 32'd1);
        send_nib(4'h0);
        check("err_k2", {31'd0, cmd_err}, 32'd0);
        send_nib(4'h0); send_nib(4'h0); send_nib(4'h2); send_nib(4'h0); send_nib(4'h0);
        send_nib(4'h5); send_nib(4'h5); send_nib(4'h6); send_nib(4'h6);
        end_txn();
        wr_active = 1'b0;
        check("ign_oe", oe_seen, 0);
        peek("ign_0200", 16'h0200, 8'h12);
        peek("ign_0201", 16'h0201, 8'h34);
        push_byte(8'h12); push_byte(8'h34);
        rd_start(24'h000200);
        rd_data(4);
        end_txn();
        check("rd_after_err_drain", exp_q.size(), 0);

        // Write aborted after a lone high nibble
        send_hdr(8'h38, 24'h000200);
        send_nib(4'h9); send_nib(4'h9); send_nib(4'hF);
        end_txn();
        peek("partial_0200", 16'h0200, 8'h99);
        peek("partial_0201", 16'h0201, 8'h34);

        // Backdoor and bus write to the same byte on the same edge
        send_hdr(8'h38, 24'h000300);
        send_nib(4'h7);
        bd_we = 1'b1; bd_addr = 16'h0300; bd_wdata = 8'hEE;
        send_nib(4'h8);
        bd_we = 1'b0;
        end_txn();
        peek("collide_0300", 16'h0300, 8'h78);

        // Read aborted by cs_n after two nibbles
        push_byte(8'hA5);
        rd_start(24'h000010);
        rd_data(2);
        end_txn();
        check("abort_oe", {31'd0, io_oe}, 32'd0);
        check("abort_io_o", {28'd0, io_o}, 32'd0);
        check("abort_drain", exp_q.size(), 0);

        // Reset during a read, then a fresh read with cs_n held low
        push_byte(8'hA5);
        rd_start(24'h000010);
        rd_data(2);
        rst = 1'b1;
        #2;
        check("rst_mid_oe", {31'd0, io_oe}, 32'd0);
        check("rst_mid_io_o", {28'd0, io_o}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        push_byte(8'hA5); push_byte(8'h3C);
        rd_start(24'h000010);
        rd_data(4);
        end_txn();
        check("rd_after_rst_drain", exp_q.size(), 0);
        peek("rst_mem_0013", 16'h0013, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
